// File: rtl/ula_video_sequencer.sv
// ULA screen-fetch sequencer: byte-slot timing, videov strobes, VAP1 address and syncs.
// Optional hires/text split region enabled by defining ULA_HIRES_TEXT_SPLIT_EN.
module ula_video_sequencer #(
    parameter int H_TOTAL        = 64,
    parameter int H_VISIBLE      = 40,
    parameter int V_VISIBLE      = 224,
    parameter int V_TOTAL_50     = 312,
    parameter int V_TOTAL_60     = 264,
    parameter int FLASH_DIV      = 16,
    parameter int HSYNC_START    = 49,
    parameter int VSYNC_START_50 = 259,
    parameter int VSYNC_START_60 = 240,
    parameter int SPLIT_LINE     = 200
) (
    input  logic        CLK_PIXEL,
    input  logic        RESET,
    input  logic        FREQ_SEL,
    input  logic        TXTHIR_SEL,
    input  logic        IS_ATTRIB,
    output logic        DATABUS_EN,
    output logic        ATTRIB_DEC,
    output logic        LDFROMBUS,
    output logic        LD_REG_0,
    output logic        RELD_REG,
    output logic        RELOAD_SEL,
    output logic        ADDR_SEL,
    output logic [15:0] VAP1,
    output logic [2:0]  CHROWCNT,
    output logic        BLANKINGn,
    output logic        HSYNCn,
    output logic        VSYNCn,
    output logic        CLK_FLASH
);
    localparam int CW = $clog2(H_TOTAL);
    localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam logic [15:0] TEXT_BASE  = 16'hBB80;
    localparam logic [15:0] HIRES_BASE = 16'hA000;
    localparam logic [15:0] STRIDE     = 16'(H_VISIBLE);
    localparam logic [15:0] SPLIT_BASE = 16'(32'hBB80 + (SPLIT_LINE / 8) * H_VISIBLE);
`ifdef ULA_HIRES_TEXT_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    logic [2:0]    phase_q, phase_d;
    logic [CW-1:0] col_q, col_d;
    logic [8:0]    line_q, line_d;
    logic [8:0]    vt_q, vt_d;
    logic          hires_q, hires_d;
    logic          att_q, att_d;
    logic [15:0]   row_base_q, row_base_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          flash_q, flash_d;
    logic          dbe_q, dbe_d, adec_q, adec_d, ldbus_q, ldbus_d, ld0_q, ld0_d;
    logic          reld_q, reld_d, relsel_q, relsel_d, asel_q, asel_d;
    logic [15:0]   vap1_q, vap1_d;
    logic          blank_q, blank_d, hs_q, hs_d, vs_q, vs_d;

    logic       phase_wrap, col_wrap, frame_wrap, active_d, textrow_d, pattern_d;
    logic [8:0] vs_start;

    // Everything is decoded from the next counter values so registered outputs line up with PHASE.
    always_comb begin
        phase_wrap = (phase_q == 3'd5);
        col_wrap   = phase_wrap && (col_q == CW'(H_TOTAL - 1));
        frame_wrap = col_wrap && (line_q == vt_q - 9'd1);

        phase_d = phase_wrap ? 3'd0 : phase_q + 3'd1;
        col_d   = col_q;
        if (phase_wrap) col_d = col_wrap ? '0 : col_q + CW'(1);
        line_d  = line_q;
        if (col_wrap) line_d = frame_wrap ? 9'd0 : line_q + 9'd1;

        hires_d = hires_q;
        vt_d    = vt_q;
        fcnt_d  = fcnt_q;
        flash_d = flash_q;
        if (frame_wrap) begin
            hires_d = TXTHIR_SEL;
            vt_d    = FREQ_SEL ? 9'(V_TOTAL_50) : 9'(V_TOTAL_60);
            if (fcnt_q == FW'(FLASH_DIV - 1)) begin
                fcnt_d  = '0;
                flash_d = !flash_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end

        textrow_d = !hires_d || (SPLIT_EN && (line_d >= 9'(SPLIT_LINE)));

        // Row base advances per line in hires, per eight lines in text.
        row_base_d = row_base_q;
        if (frame_wrap)
            row_base_d = hires_d ? HIRES_BASE : TEXT_BASE;
        else if (col_wrap) begin
            if (SPLIT_EN && hires_d && (line_d == 9'(SPLIT_LINE)))
                row_base_d = SPLIT_BASE;
            else if (!textrow_d || (line_d[2:0] == 3'd0))
                row_base_d = row_base_q + STRIDE;
        end

        active_d  = (col_d < CW'(H_VISIBLE)) && (line_d < 9'(V_VISIBLE));
        att_d     = (phase_d == 3'd3) ? IS_ATTRIB : att_q;
        pattern_d = active_d && textrow_d && !att_d;

        dbe_d    = active_d && ((phase_d == 3'd1) || ((phase_d == 3'd4) && pattern_d));
        adec_d   = active_d && (phase_d == 3'd2);
        asel_d   = pattern_d && ((phase_d == 3'd3) || (phase_d == 3'd4));
        ldbus_d  = active_d && (phase_d == 3'd5) && !att_d;
        ld0_d    = (phase_d == 3'd5) && (!active_d || att_d);
        reld_d   = (phase_d == 3'd0);
        relsel_d = (phase_d == 3'd0) && (col_d == CW'(H_TOTAL - 1));

        vap1_d   = row_base_d + 16'(col_d);
        blank_d  = (line_d < 9'(V_VISIBLE)) && (col_d != '0) && (col_d <= CW'(H_VISIBLE));
        hs_d     = !((col_d >= CW'(HSYNC_START)) && (col_d <= CW'(HSYNC_START + 3)));
        vs_start = (vt_d == 9'(V_TOTAL_50)) ? 9'(VSYNC_START_50) : 9'(VSYNC_START_60);
        vs_d     = !((line_d >= vs_start) && (line_d <= vs_start + 9'd2));
    end

    always_ff @(posedge CLK_PIXEL) begin
        if (RESET) begin
            phase_q    <= '0;
            col_q      <= '0;
            line_q     <= '0;
            vt_q       <= 9'(V_TOTAL_50);
            hires_q    <= 1'b0;
            att_q      <= 1'b0;
            row_base_q <= TEXT_BASE;
            fcnt_q     <= '0;
            flash_q    <= 1'b0;
            dbe_q      <= 1'b0;
            adec_q     <= 1'b0;
            ldbus_q    <= 1'b0;
            ld0_q      <= 1'b0;
            reld_q     <= 1'b0;
            relsel_q   <= 1'b0;
            asel_q     <= 1'b0;
            vap1_q     <= TEXT_BASE;
            blank_q    <= 1'b0;
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
        end else begin
            phase_q    <= phase_d;
            col_q      <= col_d;
            line_q     <= line_d;
            vt_q       <= vt_d;
            hires_q    <= hires_d;
            att_q      <= att_d;
            row_base_q <= row_base_d;
            fcnt_q     <= fcnt_d;
            flash_q    <= flash_d;
            dbe_q      <= dbe_d;
            adec_q     <= adec_d;
            ldbus_q    <= ldbus_d;
            ld0_q      <= ld0_d;
            reld_q     <= reld_d;
            relsel_q   <= relsel_d;
            asel_q     <= asel_d;
            vap1_q     <= vap1_d;
            blank_q    <= blank_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
        end
    end

    assign DATABUS_EN = dbe_q;
    assign ATTRIB_DEC = adec_q;
    assign LDFROMBUS  = ldbus_q;
    assign LD_REG_0   = ld0_q;
    assign RELD_REG   = reld_q;
    assign RELOAD_SEL = relsel_q;
    assign ADDR_SEL   = asel_q;
    assign VAP1       = vap1_q;
    assign CHROWCNT   = line_q[2:0];
    assign BLANKINGn  = blank_q;
    assign HSYNCn     = hs_q;
    assign VSYNCn     = vs_q;
    assign CLK_FLASH  = flash_q;
endmodule

// File: tb/tb_ula_video_sequencer.sv
// Bench for ula_video_sequencer: a full-size instance (text frame) and a short-frame
// instance (mode latch, split, 60 Hz, flash) checked every cycle against a position model.
module tb_ula_video_sequencer;
`ifdef ULA_HIRES_TEXT_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif
    localparam int VV[2]   = '{224, 12};
    localparam int VT50[2] = '{312, 20};
    localparam int VT60[2] = '{264, 14};
    localparam int FD[2]   = '{16, 2};
    localparam int VS50[2] = '{259, 15};
    localparam int VS60[2] = '{240, 10};
    localparam int SPL[2]  = '{200, 8};
    localparam int LINE_CYC = 64 * 6;

    logic clk, RESET, FREQ_SEL, TXTHIR_SEL, IS_ATTRIB;
    logic [1:0] dbe, adec, ldbus, ld0, reld, relsel, asel, blank, hs, vs, flash;
    logic [15:0] vap [2];
    logic [2:0]  chrow [2];
    logic [29:0] dv [2];

    int vectors = 0, miscompares = 0, cyc = 0;
    bit started = 0;
    int pos[2], fr[2], m_vt[2], m_fc[2];
    bit m_hires[2], m_att[2], m_flash[2], m_jr[2];
    int fst[4];

    ula_video_sequencer dut0 (
        .CLK_PIXEL(clk), .RESET(RESET), .FREQ_SEL(FREQ_SEL), .TXTHIR_SEL(TXTHIR_SEL),
        .IS_ATTRIB(IS_ATTRIB), .DATABUS_EN(dbe[0]), .ATTRIB_DEC(adec[0]), .LDFROMBUS(ldbus[0]),
        .LD_REG_0(ld0[0]), .RELD_REG(reld[0]), .RELOAD_SEL(relsel[0]), .ADDR_SEL(asel[0]),
        .VAP1(vap[0]), .CHROWCNT(chrow[0]), .BLANKINGn(blank[0]), .HSYNCn(hs[0]),
        .VSYNCn(vs[0]), .CLK_FLASH(flash[0]));

    ula_video_sequencer #(
        .V_VISIBLE(12), .V_TOTAL_50(20), .V_TOTAL_60(14), .FLASH_DIV(2),
        .VSYNC_START_50(15), .VSYNC_START_60(10), .SPLIT_LINE(8)
    ) dut1 (
        .CLK_PIXEL(clk), .RESET(RESET), .FREQ_SEL(FREQ_SEL), .TXTHIR_SEL(TXTHIR_SEL),
        .IS_ATTRIB(IS_ATTRIB), .DATABUS_EN(dbe[1]), .ATTRIB_DEC(adec[1]), .LDFROMBUS(ldbus[1]),
        .LD_REG_0(ld0[1]), .RELD_REG(reld[1]), .RELOAD_SEL(relsel[1]), .ADDR_SEL(asel[1]),
        .VAP1(vap[1]), .CHROWCNT(chrow[1]), .BLANKINGn(blank[1]), .HSYNCn(hs[1]),
        .VSYNCn(vs[1]), .CLK_FLASH(flash[1]));

    assign dv[0] = {dbe[0], adec[0], ldbus[0], ld0[0], reld[0], relsel[0], asel[0],
                    blank[0], hs[0], vs[0], flash[0], chrow[0], vap[0]};
    assign dv[1] = {dbe[1], adec[1], ldbus[1], ld0[1], reld[1], relsel[1], asel[1],
                    blank[1], hs[1], vs[1], flash[1], chrow[1], vap[1]};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Beam position model: pos counts cycles since frame start.
    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (RESET) begin
                started = 1;
                pos[i] = 0; fr[i] = 0; m_hires[i] = 0; m_vt[i] = VT50[i];
                m_fc[i] = 0; m_flash[i] = 0; m_att[i] = 0; m_jr[i] = 1;
            end else begin
                m_jr[i] = 0;
                pos[i]++;
                if (pos[i] == m_vt[i] * LINE_CYC) begin
                    pos[i] = 0;
                    fr[i]++;
                    if (i == 1 && fr[i] < 4) fst[fr[i]] = cyc;
                    m_hires[i] = TXTHIR_SEL;
                    m_vt[i] = FREQ_SEL ? VT50[i] : VT60[i];
                    if (m_fc[i] == FD[i] - 1) begin
                        m_fc[i] = 0;
                        m_flash[i] = !m_flash[i];
                    end else m_fc[i]++;
                end
                if (pos[i] % 6 == 3) m_att[i] = IS_ATTRIB;
            end
        end
    end

    function automatic logic [29:0] model_out(input int i);
        int ln, cl, ph, vs0;
        bit act, tr, pat;
        logic [15:0] va;
        ln  = pos[i] / LINE_CYC;
        cl  = (pos[i] / 6) % 64;
        ph  = pos[i] % 6;
        act = (cl < 40) && (ln < VV[i]);
        tr  = !m_hires[i] || (SPLIT && ln >= SPL[i]);
        pat = act && tr && !m_att[i];
        va  = tr ? 16'(32'hBB80 + (ln / 8) * 40 + cl) : 16'(32'hA000 + ln * 40 + cl);
        vs0 = (m_vt[i] == VT50[i]) ? VS50[i] : VS60[i];
        return {act && (ph == 1 || (ph == 4 && pat)), act && ph == 2,
                act && ph == 5 && !m_att[i], ph == 5 && (!act || m_att[i]),
                ph == 0 && !m_jr[i], cl == 63 && ph == 0 && !m_jr[i],
                pat && (ph == 3 || ph == 4), ln < VV[i] && cl >= 1 && cl <= 40,
                !(cl >= 49 && cl <= 52), !(ln >= vs0 && ln <= vs0 + 2),
                m_flash[i], 3'(ln % 8), va};
    endfunction

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            int l0, c0, p0, l1, c1, p1;
            for (int i = 0; i < 2; i++) begin
                logic [29:0] e;
                e = model_out(i);
                vectors++;
                if (dv[i] !== e) begin
                    miscompares++;
                    $display("FAIL cycle_inst%0d cyc %0d pos %0d: got %h required %h",
                             i, cyc, pos[i], dv[i], e);
                end
            end
            l0 = pos[0] / LINE_CYC; c0 = (pos[0] / 6) % 64; p0 = pos[0] % 6;
            l1 = pos[1] / LINE_CYC; c1 = (pos[1] / 6) % 64; p1 = pos[1] % 6;
            if (m_jr[0]) begin
                lit("reset_vap1", 32'(vap[0]), 32'hBB80);
                lit("reset_strobes", 32'({dbe[0], adec[0], reld[0], ld0[0], asel[0]}), 0);
                lit("reset_video", 32'({blank[0], hs[0], vs[0], flash[0]}), 32'b0110);
            end
            if (!m_jr[0] && pos[0] == 1) lit("first_databus_en", 32'(dbe[0]), 1);
            if (!m_jr[0] && pos[0] == 2) lit("first_attrib_dec", 32'(adec[0]), 1);
            if (pos[0] == 5) lit("blank_col0", 32'(blank[0]), 0);
            if (pos[0] == 6) lit("blank_col1", 32'(blank[0]), 1);
            if (l0 == 9 && c0 == 5 && p0 == 0) begin
                lit("text_vap1_l9c5", 32'(vap[0]), 32'hBBAD);
                lit("chrowcnt_l9", 32'(chrow[0]), 1);
            end
            if (l0 == 1 && c0 == 3 && p0 == 3) lit("attr_addr_sel", 32'(asel[0]), 0);
            if (l0 == 1 && c0 == 3 && p0 == 4) lit("attr_no_2nd_fetch", 32'(dbe[0]), 0);
            if (l0 == 1 && c0 == 3 && p0 == 5) lit("attr_ld_reg_0", 32'({ld0[0], ldbus[0]}), 2);
            if (l0 == 1 && c0 == 4 && p0 == 3) lit("text_addr_sel", 32'(asel[0]), 1);
            if (l0 == 1 && c0 == 4 && p0 == 4) lit("text_2nd_fetch", 32'(dbe[0]), 1);
            if (l0 == 1 && c0 == 4 && p0 == 5) lit("text_ldfrombus", 32'({ld0[0], ldbus[0]}), 1);
            if (l0 == 0 && c0 == 63 && p0 == 0) lit("reload_sel", 32'(relsel[0]), 1);
            if (l0 == 0 && c0 == 49 && p0 == 0) lit("hsync_start", 32'(hs[0]), 0);
            if (l0 == 0 && c0 == 53 && p0 == 0) lit("hsync_end", 32'(hs[0]), 1);
            if (fr[1] == 0 && l1 == 10 && c1 == 0 && p1 == 0)
                lit("text_until_frame_end", 32'(vap[1]), 32'hBBA8);
            if (fr[1] == 1 && l1 == 2 && c1 == 0 && p1 == 0)
                lit("hires_vap1_l2", 32'(vap[1]), 32'hA050);
            if (fr[1] == 1 && l1 == 2 && c1 == 0 && p1 == 4)
                lit("hires_single_fetch", 32'({dbe[1], asel[1]}), 0);
            if (fr[1] == 1 && l1 == 8 && c1 == 0 && p1 == 0)
                lit("split_vap1", 32'(vap[1]), SPLIT ? 32'hBBA8 : 32'hA140);
            if (fr[1] == 1 && l1 == 15 && c1 == 0 && p1 == 0) lit("vsync_50", 32'(vs[1]), 0);
            if (fr[1] == 2 && l1 == 10 && c1 == 0 && p1 == 0) lit("vsync_60", 32'(vs[1]), 0);
            if (fr[1] == 2 && l1 == 13 && c1 == 0 && p1 == 0) lit("vsync_60_end", 32'(vs[1]), 1);
            if (pos[1] == 0 && fr[1] == 1) lit("flash_f1", 32'(flash[1]), 0);
            if (pos[1] == 0 && fr[1] == 2) lit("flash_f2", 32'(flash[1]), 1);
            if (pos[1] == 0 && fr[1] == 3) begin
                lit("flash_f3", 32'(flash[1]), 1);
                lit("frame1_len_50", 32'(fst[2] - fst[1]), 20 * LINE_CYC);
                lit("frame2_len_60", 32'(fst[3] - fst[2]), 14 * LINE_CYC);
            end
        end
    end

    // videov stand-in: bytes in columns 3, 7, 11, ... are attributes.
    initial begin
        IS_ATTRIB = 1'b0;
        forever @(negedge clk) IS_ATTRIB = (((pos[0] / 6) % 64) % 4 == 3);
    end

    initial begin
        RESET = 1'b1; FREQ_SEL = 1'b1; TXTHIR_SEL = 1'b0;
        repeat (3) @(posedge clk);
        #1 RESET = 1'b0;
        repeat (3) @(posedge clk);
        #1 RESET = 1'b1;
        @(posedge clk);
        #1 RESET = 1'b0;
        repeat (3000) @(posedge clk);
        #1 TXTHIR_SEL = 1'b1;
        repeat (7000) @(posedge clk);
        #1 FREQ_SEL = 1'b0;
        repeat (17500) @(posedge clk);
        #1 lit("frames_reached", 32'(fr[1] >= 3), 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ula_video_sequencer.md
# ula_video_sequencer

Generates the ULA screen-fetch timing and strobe sequence consumed by `videov`: it drives `DATABUS_EN`, `ATTRIB_DEC`, `LDFROMBUS`, `LD_REG_0`, `RELD_REG`, `RELOAD_SEL`, `CHROWCNT`, `BLANKINGn` and `CLK_FLASH`. It also produces the phase-1 screen address (VAP1), the VAP1/VAP2 address-select, and the video syncs. It sits between the pixel clock domain top level and `videov`, and closes the loop using `videov`'s `isAttrib` and mode outputs.

## Interface
- H_TOTAL, 64, byte slots per line
- H_VISIBLE, 40, fetched byte slots per line
- V_VISIBLE, 224, displayed lines
- V_TOTAL_50, 312, lines per 50 Hz frame
- V_TOTAL_60, 264, lines per 60 Hz frame
- FLASH_DIV, 16, frames per `CLK_FLASH` half-period
- Clock and reset: one clock; reset is synchronous and active-high.
- CLK_PIXEL  in  1  6 MHz pixel clock; the only clock
- RESET  in  1  synchronous, active-high reset
- FREQ_SEL  in  1  1 = 50 Hz, 0 = 60 Hz (from `videov`)
- TXTHIR_SEL  in  1  1 = hires, 0 = text (from `videov`)
- IS_ATTRIB  in  1  current byte is an attribute (from `videov`)
- DATABUS_EN, ATTRIB_DEC, LDFROMBUS, LD_REG_0, RELD_REG, RELOAD_SEL  out  1 each  one-cycle strobes
- ADDR_SEL  out  1  0 = VAP1 on the memory bus, 1 = VAP2
- VAP1  out  16  screen byte address
- CHROWCNT  out  3  character scanline
- BLANKINGn, HSYNCn, VSYNCn  out  1 each  video control, active low
- CLK_FLASH  out  1  flash phase

## Operation
- Counters:
  - PHASE runs 0..5.
  - COL runs 0..H_TOTAL-1 and increments when PHASE wraps.
  - LINE runs 0..VT-1 and increments when COL wraps.
- Frame mode latch: FREQ_SEL and TXTHIR_SEL are sampled into HIRES/VT only in the cycle LINE=0, COL=0, PHASE=0. Mid-frame changes take effect at the next frame.
- Fetch slot: a slot is active when COL<H_VISIBLE and LINE<V_VISIBLE. TEXTROW is true when the line is displayed as text: either HIRES=0, or the split region under the configuration macro.
- Active slot sequence:
  - PHASE0: ADDR_SEL=0.
  - PHASE1: DATABUS_EN.
  - PHASE2: ATTRIB_DEC.
  - PHASE3: IS_ATTRIB is sampled into ATT. If TEXTROW and !ATT, ADDR_SEL=1 for PHASE3-4.
  - PHASE4: DATABUS_EN again, only if TEXTROW and !ATT (pattern fetch).
  - PHASE5: LD_REG_0 if ATT, else LDFROMBUS.
- RELD_REG fires at PHASE0 of every slot, including inactive slots.
- Inactive slots issue no DATABUS_EN, ATTRIB_DEC or LDFROMBUS. They issue LD_REG_0 at PHASE5.
- RELOAD_SEL fires at COL=H_TOTAL-1, PHASE0 on every line.
- Address generation:
  - Text: VAP1 = 0xBB80 + (LINE>>3)*40 + COL.
  - Hires: VAP1 = 0xA000 + LINE*40 + COL.
  - Arithmetic is 16-bit modulo. The row base is kept as an incremental accumulator, not a multiplier.
- CHROWCNT = LINE[2:0].
- BLANKINGn is high when LINE<V_VISIBLE and 1≤COL≤H_VISIBLE. This is one slot late, to match the shifter latency.
- HSYNCn is low for COL 49..52.
- VSYNCn is low for LINE 259..261 (VT=312) or 240..242 (VT=264).
- CLK_FLASH toggles at frame start every FLASH_DIV frames.

## Timing
- All outputs are registered. A strobe "at phase k" is high exactly for the single cycle in which PHASE==k; this is decoded one cycle early and registered.
- Pixel latency: byte of slot N is loaded at PHASE5 and shifted out during slot N+1.
- Reset values:
  - Counters 0; HIRES=0; VT=V_TOTAL_50.
  - All strobes 0; ADDR_SEL=0.
  - VAP1=0xBB80; CHROWCNT=0.
  - BLANKINGn=0; HSYNCn=1; VSYNCn=1; CLK_FLASH=0.
  - The flash frame counter is 0.
- Reset asserted mid-slot: the next cycle shows reset values, and strobes are not completed.
- FREQ_SEL change while LINE ≥ new VT: no issue, because VT only updates at LINE=0.
- Wrap: LINE=VT-1, COL=63, PHASE=5 → next cycle is LINE=0, COL=0, PHASE=0. The mode latch and CLK_FLASH update happen in that cycle.

## Configuration
- ULA_HIRES_TEXT_SPLIT_EN defined:
  - In hires, lines ≥200 are TEXTROW.
  - They use text addressing from 0xBB80 + (LINE>>3)*40 + COL, which gives rows 25..27, i.e. 0xBF68 at LINE 200.
- Undefined: hires addressing covers all V_VISIBLE lines, and TEXTROW = !HIRES.

## Test plan
- Reset, release → VAP1=0xBB80; the first DATABUS_EN comes at cycle 1 and ATTRIB_DEC at cycle 2; BLANKINGn=0 until COL=1.
- Text mode, IS_ATTRIB=0 → per slot: 2×DATABUS_EN (phases 1 and 4), ADDR_SEL=1 on phases 3-4, LDFROMBUS at phase 5. At LINE=9, COL=5: VAP1=0xBBAD and CHROWCNT=1.
- IS_ATTRIB=1 at phase 3 → a single DATABUS_EN, no ADDR_SEL=1, LD_REG_0 at phase 5.
- TXTHIR_SEL=1 asserted mid-frame → text addressing continues until LINE=0. In the next frame at LINE=2, COL=0: VAP1=0xA050, with one DATABUS_EN per slot.
- FREQ_SEL 1→0 → the current frame still lasts 312 lines and the next lasts 264. VSYNCn is low on lines 240..242. CLK_FLASH toggles after 16 frames.
- Hires at LINE=200, COL=0 → VAP1=0xBF68 with the macro defined, 0xBF40 without.
